weight_loader: RTL and testbench
================================

# weight_loader

Command-driven fetch engine between `weight_buffer` and the matrix multiply unit's weight-preload interface. It accepts a load command (base weight address, row count) and issues one read per row on a single weight buffer port. It tracks the fixed read latency and buffers returned rows in a small FIFO, then presents them downstream in order over a valid/ready handshake with a row index and a last flag.

## Interface
- `MATRIX_WIDTH`, 4: bytes per row and maximum rows per command
- `READ_LATENCY`, 3: cycles from `buf_en` high to valid `buf_data`; must be ≥1
- `FIFO_DEPTH`, 4: return-row buffer depth; full throughput requires `FIFO_DEPTH ≥ READ_LATENCY+1`
- `clk` in 1: the only clock
- `rst` in 1: synchronous, active-low reset
- `enable` in 1: global advance; low freezes all state and forces `buf_en`=0
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_addr` in `weight_addr_type`: base address
- `cmd_rows` in `$clog2(MATRIX_WIDTH+1)`: rows to load
- `buf_en` out 1, `buf_addr` out `weight_addr_type`: read request to weight buffer port
- `buf_data` in `byte_type [MATRIX_WIDTH-1:0]`: read data
- `row_valid` out 1 / `row_ready` in 1: row handshake
- `row_data` out `byte_type [MATRIX_WIDTH-1:0]`, `row_index` out `$clog2(MATRIX_WIDTH)`, `row_last` out 1
- `busy` out 1, `done` out 1 (single-cycle pulse)

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- **IDLE**
  - `cmd_ready` = `enable`.
  - Accept a command on `cmd_valid & cmd_ready`.
  - `cmd_rows` above `MATRIX_WIDTH` is clamped to `MATRIX_WIDTH`.
  - `cmd_rows`=0 produces no reads; `done` pulses the next cycle and the FSM stays in IDLE.
  - Otherwise latch base and rows, then go to FETCH.
- **FETCH**
  - Issue condition: `outstanding + fifo_count < FIFO_DEPTH` (credit rule).
  - Each cycle that meets the condition asserts `buf_en` with `buf_addr` = base+issued, then increments issued.
  - Address addition wraps modulo the `weight_addr_type` width.
  - When issued equals rows, go to DRAIN.
- **Read tracking**
  - A `READ_LATENCY`-deep valid shift register tracks reads in flight.
  - Its output writes `buf_data` into the FIFO.
  - The credit rule guarantees the FIFO never overflows.
- **DRAIN**
  - Wait for the handshake of the row with `row_last`=1.
  - Then pulse `done` and return to IDLE.
- **Output ordering**
  - Rows leave in issue order.
  - `row_index` counts 0 upward per command.
  - `row_last`=1 only on the final row.
- `busy` = state≠IDLE.
- `row_data` is held stable while `row_valid & !row_ready`.
- **`enable` low**
  - FSM, counters, shift register and FIFO freeze.
  - `buf_en`=0.
  - Outputs hold their values.
  - No handshake completes.
- **`rst` low**
  - Mid-operation reset returns the FSM to IDLE, empties the FIFO and clears the shift register, discarding in-flight data.
- **Reset values:** `buf_en` 0, `buf_addr` 0, `row_valid` 0, `row_data` 0, `row_index` 0, `row_last` 0, `busy` 0, `done` 0, `cmd_ready` 1 (with `enable` high).

## Timing
- Command accepted at edge T → first `buf_en` in cycle T+1.
- Read issued in cycle C → `buf_data` valid in C+`READ_LATENCY` → captured at the end of that cycle → `row_valid` from C+`READ_LATENCY`+1.
- First `row_valid` is therefore cycle T+2+`READ_LATENCY`.
- With `row_ready` held high and sufficient depth: one read and one row per cycle.
- `done` is high in the cycle after the last-row handshake; `cmd_ready` is high in that same cycle.
- Back-to-back commands: no overlap; a new command is only accepted in IDLE.

## Configuration
- `WEIGHT_LOADER_ZERO_PAD_EN` defined:
  - After the real rows, emit zero rows with indices rows..`MATRIX_WIDTH`-1, issuing no reads for them.
  - `row_last` falls on index `MATRIX_WIDTH`-1.
  - `cmd_rows`=0 emits `MATRIX_WIDTH` zero rows.
- `WEIGHT_LOADER_ZERO_PAD_EN` undefined:
  - Only the requested rows are emitted.
  - `row_last` falls on index rows-1.

## Structure
- `tpu_pkg`: reuse `weight_addr_type` and `byte_type`; add enum `weight_loader_state_type` (IDLE/FETCH/DRAIN).
- One sub-module, `weight_loader_fifo`: synchronous FIFO with parameterised depth and width, an `enable` input, and synchronous active-low reset.

## Test plan
- **Single command:** reset, then cmd addr=5, rows=4, `row_ready`=1 → `buf_addr` 5,6,7,8 on consecutive cycles; rows 0..3 match buffer contents; `row_last` on index 3; `done` one cycle later.
- **Backpressure:** `row_ready` toggling 1-0-0-1 → no row lost or duplicated; `row_data` stable while stalled; `buf_en` never issued beyond credits.
- **Wrap and clamp:** cmd addr=max−1, rows=7 with `MATRIX_WIDTH`=4 → addresses max−1, max, 0, 1; exactly 4 rows emitted.
- **Zero rows:** rows=0 → no `buf_en`; `done` next cycle. With `WEIGHT_LOADER_ZERO_PAD_EN`: 4 zero rows emitted instead.
- **Pad:** with `WEIGHT_LOADER_ZERO_PAD_EN`, rows=2 → 2 real rows, then 2 zero rows at indices 2,3.
- **Interruptions:**
  - `enable` low for 3 cycles mid-FETCH → the output row sequence is unchanged and shifted by 3 cycles.
  - `rst` low mid-FETCH → next cycle idle outputs; a following command behaves normally.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU types: weight-buffer address, byte lanes, and the weight loader FSM encoding.
package tpu_pkg;

  localparam int WEIGHT_ADDR_WIDTH = 8;
  localparam int BYTE_WIDTH        = 8;

  typedef logic [BYTE_WIDTH-1:0]        byte_type;
  typedef logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } weight_loader_state_type;

endpackage

// File: rtl/weight_loader_fifo.sv
// Show-ahead synchronous FIFO for returned weight rows; the head entry is visible on rd_data
// while the FIFO is non-empty. All state advances only when enable is high.
module weight_loader_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 32,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_wr   = enable & wr_en & ~full;
  assign do_rd   = enable & rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; entries are only observable after a write, and the consumer masks the empty head.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/weight_loader.sv
// Command-driven weight row fetcher: issues buffer reads under a FIFO credit rule and streams rows out.
// Optional feature: define WEIGHT_LOADER_ZERO_PAD_EN to pad every command to MATRIX_WIDTH rows with zero rows.
module weight_loader
  import tpu_pkg::*;
#(
  parameter int  MATRIX_WIDTH = 4,
  parameter int  READ_LATENCY = 3,
  parameter int  FIFO_DEPTH   = 4,
  localparam int RW           = $clog2(MATRIX_WIDTH + 1),
  localparam int IW           = $clog2(MATRIX_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  weight_addr_type               cmd_addr,
  input  logic [RW-1:0]                 cmd_rows,
  output logic                          buf_en,
  output weight_addr_type               buf_addr,
  input  byte_type [MATRIX_WIDTH-1:0]   buf_data,
  output logic                          row_valid,
  input  logic                          row_ready,
  output byte_type [MATRIX_WIDTH-1:0]   row_data,
  output logic [IW-1:0]                 row_index,
  output logic                          row_last,
  output logic                          busy,
  output logic                          done
);

`ifdef WEIGHT_LOADER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(READ_LATENCY + 1);
  localparam int DW = MATRIX_WIDTH * $bits(byte_type);

  weight_loader_state_type state_q, state_d;
  weight_addr_type         base_q, base_d;
  logic [RW-1:0]           rows_q, rows_d;
  logic [RW-1:0]           issued_q, issued_d;
  logic [RW-1:0]           out_idx_q, out_idx_d;
  logic [READ_LATENCY-1:0] sr_q, sr_d;
  logic                    done_q, done_d;

  logic [RW-1:0]           rows_clamped;
  logic [RW-1:0]           last_idx;
  logic [OW-1:0]           outstanding;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [DW-1:0]           fifo_rd_data;
  logic                    credit_ok;
  logic                    real_phase;
  logic                    cmd_acc;
  logic                    row_hs;
  logic                    last_hs;

  assign rows_clamped = (cmd_rows > RW'(MATRIX_WIDTH)) ? RW'(MATRIX_WIDTH) : cmd_rows;
  assign last_idx     = PAD_EN ? RW'(MATRIX_WIDTH - 1) : rows_q - RW'(1);
  assign real_phase   = (out_idx_q < rows_q);
  assign cmd_acc      = cmd_valid & cmd_ready;
  assign row_hs       = enable & row_valid & row_ready;
  assign last_hs      = row_hs & row_last;

  // Reads still in flight plus rows already buffered must leave room for the read being issued.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < READ_LATENCY; i++) outstanding = outstanding + OW'(sr_q[i]);
  end
  assign credit_ok = (32'(outstanding) + 32'(fifo_count)) < 32'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else if (enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          if (rows_clamped != '0) state_d = FETCH;
          else if (PAD_EN)        state_d = DRAIN;
        end
      end
      FETCH: if (buf_en && (issued_q + RW'(1) == rows_q)) state_d = DRAIN;
      DRAIN: if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    cmd_ready = enable && (state_q == IDLE);
    buf_en    = enable && (state_q == FETCH) && (issued_q < rows_q) && credit_ok;
    buf_addr  = base_q + weight_addr_type'(issued_q);
    row_valid = busy && (real_phase ? !fifo_empty : PAD_EN);
    row_data  = (row_valid && real_phase) ? fifo_rd_data : '0;
    row_index = out_idx_q[IW-1:0];
    row_last  = row_valid && (out_idx_q == last_idx);
    done      = done_q;
  end

  always_comb begin
    base_d    = base_q;
    rows_d    = rows_q;
    issued_d  = issued_q;
    out_idx_d = out_idx_q;
    done_d    = 1'b0;
    sr_d      = (sr_q << 1) | READ_LATENCY'(buf_en);
    if (cmd_acc) begin
      base_d    = cmd_addr;
      rows_d    = rows_clamped;
      issued_d  = '0;
      out_idx_d = '0;
      done_d    = (rows_clamped == '0) && !PAD_EN;
    end
    if (buf_en) issued_d = issued_q + RW'(1);
    if (row_hs) out_idx_d = last_hs ? '0 : out_idx_q + RW'(1);
    if (last_hs) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q    <= '0;
      rows_q    <= '0;
      issued_q  <= '0;
      out_idx_q <= '0;
      sr_q      <= '0;
      done_q    <= 1'b0;
    end else if (enable) begin
      base_q    <= base_d;
      rows_q    <= rows_d;
      issued_q  <= issued_d;
      out_idx_q <= out_idx_d;
      sr_q      <= sr_d;
      done_q    <= done_d;
    end
  end

  // Pad rows never enter the FIFO; only real rows pop it.
  weight_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .wr_en   (sr_q[READ_LATENCY-1]),
    .wr_data (buf_data),
    .rd_en   (row_hs & real_phase),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader with a latency-accurate weight buffer model.
module tb_weight_loader;
  import tpu_pkg::*;

  localparam int MW  = 4;
  localparam int LAT = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 cmd_valid;
  logic                 cmd_ready;
  weight_addr_type      cmd_addr;
  logic [2:0]           cmd_rows;
  logic                 buf_en;
  weight_addr_type      buf_addr;
  byte_type [MW-1:0]    buf_data;
  logic                 row_valid;
  logic                 row_ready;
  byte_type [MW-1:0]    row_data;
  logic [1:0]           row_index;
  logic                 row_last;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_pass   = 0;

  weight_addr_type iss_addr_q[$];
  int              iss_cyc_q[$];
  logic [31:0]     row_data_q[$];
  int              row_idx_q[$];
  logic            row_last_q[$];
  int              row_cyc_q[$];
  int              done_cyc;

  weight_addr_type pipe_addr [LAT] = '{default: '0};
  logic            pipe_vld  [LAT] = '{default: 1'b0};

  always #5 clk = ~clk;

  weight_loader #(
    .MATRIX_WIDTH (MW),
    .READ_LATENCY (LAT),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rows  (cmd_rows),
    .buf_en    (buf_en),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_index (row_index),
    .row_last  (row_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [31:0] mem(input weight_addr_type a);
    return {a * 8'd3, a ^ 8'hFF, a + 8'h11, a};
  endfunction

  // Weight buffer model: fixed read latency, stalled together with the loader by enable.
  always @(posedge clk) begin
    if (enable) begin
      pipe_vld[0]  <= buf_en;
      pipe_addr[0] <= buf_addr;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end
  assign buf_data = pipe_vld[LAT-1] ? mem(pipe_addr[LAT-1]) : '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue_cmd(input weight_addr_type a, input logic [2:0] r);
    @(negedge clk);
    enable    = 1'b1;
    row_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rows  = r;
    #1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
  endtask

  // Cycle k=1 is the cycle after the accepting edge; records issues, row handshakes and done.
  task automatic collect(input logic [31:0] rdy_pat, input logic [31:0] en_pat, input int budget);
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [4:0]  bi;
    iss_addr_q.delete(); iss_cyc_q.delete();
    row_data_q.delete(); row_idx_q.delete(); row_last_q.delete(); row_cyc_q.delete();
    done_cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      bi        = 5'(k - 1);
      cmd_valid = 1'b0;
      row_ready = rdy_pat[bi];
      enable    = en_pat[bi];
      #1;
      if (prev_stall) begin
        check("stall_valid", 32'(row_valid), 32'd1);
        check("stall_data", row_data, prev_data);
      end
      if (!enable) check("en_low_buf_en", 32'(buf_en), 32'd0);
      if (buf_en) begin
        check("credit", 32'((iss_addr_q.size() - row_data_q.size()) < 4), 32'd1);
        iss_addr_q.push_back(buf_addr);
        iss_cyc_q.push_back(k);
      end
      if (row_valid && row_ready && enable) begin
        row_data_q.push_back(row_data);
        row_idx_q.push_back(int'(row_index));
        row_last_q.push_back(row_last);
        row_cyc_q.push_back(k);
      end
      if (done) begin
        done_cyc = k;
        check("done_cmd_ready", 32'(cmd_ready), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        break;
      end
      prev_stall = row_valid && !(row_ready && enable);
      prev_data  = row_data;
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_run(input string tag, input weight_addr_type a, input int n_iss,
                           input logic [31:0] iss_cyc, input int n_real, input int n_rows,
                           input logic [31:0] row_cyc, input int done_exp);
    logic [31:0]     tmp;
    weight_addr_type ea;
    check({tag, "_n_iss"}, 32'(iss_addr_q.size()), 32'(n_iss));
    for (int i = 0; i < n_iss && i < iss_addr_q.size(); i++) begin
      ea  = a + weight_addr_type'(i);
      tmp = iss_cyc >> (8 * i);
      check({tag, "_iss_addr"}, 32'(iss_addr_q[i]), 32'(ea));
      check({tag, "_iss_cyc"}, 32'(iss_cyc_q[i]), 32'(tmp[7:0]));
    end
    check({tag, "_n_rows"}, 32'(row_data_q.size()), 32'(n_rows));
    for (int i = 0; i < n_rows && i < row_data_q.size(); i++) begin
      ea  = a + weight_addr_type'(i);
      tmp = row_cyc >> (8 * i);
      check({tag, "_row_data"}, row_data_q[i], (i < n_real) ? mem(ea) : 32'd0);
      check({tag, "_row_idx"}, 32'(row_idx_q[i]), 32'(i));
      check({tag, "_row_last"}, 32'(row_last_q[i]), 32'(i == n_rows - 1));
      check({tag, "_row_cyc"}, 32'(row_cyc_q[i]), 32'(tmp[7:0]));
    end
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(done_exp));
  endtask

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rows  = '0;
    row_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_buf_en", 32'(buf_en), 32'd0);
    check("rst_buf_addr", 32'(buf_addr), 32'd0);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_row_data", row_data, 32'd0);
    check("rst_row_index", 32'(row_index), 32'd0);
    check("rst_row_last", 32'(row_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single command, full throughput.
    issue_cmd(8'h05, 3'd4);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("single", 8'h05, 4, 32'h04_03_02_01, 4, 4, 32'h08_07_06_05, 9);
    @(negedge clk);
    #1;
    check("done_single_pulse", 32'(done), 32'd0);

    // Backpressure: row_ready 1,0,0,1 repeating.
    issue_cmd(8'h20, 3'd4);
    collect(32'h9999_9999, 32'hFFFF_FFFF, 40);
    check_run("bp", 8'h20, 4, 32'h04_03_02_01, 4, 4, 32'h0C_09_08_05, 13);

    // Address wrap with clamp of 7 rows down to 4.
    issue_cmd(8'hFE, 3'd7);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("wrap", 8'hFE, 4, 32'h04_03_02_01, 4, 4, 32'h08_07_06_05, 9);

`ifdef WEIGHT_LOADER_ZERO_PAD_EN
    issue_cmd(8'h33, 3'd0);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("zero", 8'h33, 0, 32'h0, 0, 4, 32'h04_03_02_01, 5);

    issue_cmd(8'h80, 3'd2);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("pad", 8'h80, 2, 32'h02_01, 2, 4, 32'h08_07_06_05, 9);
`else
    issue_cmd(8'h33, 3'd0);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("zero", 8'h33, 0, 32'h0, 0, 0, 32'h0, 1);

    issue_cmd(8'h80, 3'd2);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("two", 8'h80, 2, 32'h02_01, 2, 2, 32'h06_05, 7);
`endif

    // enable low for cycles 3..5 mid-FETCH shifts everything after it by 3 cycles.
    issue_cmd(8'h40, 3'd4);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFE3, 40);
    check_run("enable", 8'h40, 4, 32'h07_06_02_01, 4, 4, 32'h0B_0A_09_08, 12);

    // Reset mid-FETCH, then a normal command.
    issue_cmd(8'h60, 3'd4);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_buf_en", 32'(buf_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_row_valid", 32'(row_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_buf_addr", 32'(buf_addr), 32'd0);
    issue_cmd(8'h10, 3'd3);
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40);
    check_run("after_rst", 8'h10, 3, 32'h03_02_01, 3, 3, 32'h07_06_05, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
